// File: rtl/reg_file_sb.sv
// Register file for the ID/WB boundary: NUM_RD combinational read ports, one write port,
// optional same-cycle write bypass, optional hardwired zero register and a per-register pending scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_stall,
    output logic [(1<<ADDR_W)-1:0]     pend_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  pend_reg;
    logic              wr_keep;
    logic              iss_set;

    assign wr_keep   = wr_en && !(ZERO_REG && (wr_addr == '0));
    assign iss_stall = iss_en && pend_reg[iss_addr] && !(wr_en && (wr_addr == iss_addr));
    assign iss_set   = iss_en && !iss_stall && !(ZERO_REG && (iss_addr == '0));
    assign pend_vec  = pend_reg;

    // The issue set is placed after the writeback clear so a same-address set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= DATA_W'(i);
            end
            pend_reg <= '0;
        end else begin
            if (wr_keep) begin
                regs_reg[wr_addr] <= wr_data;
            end
            if (wr_en) begin
                pend_reg[wr_addr] <= 1'b0;
            end
            if (iss_set) begin
                pend_reg[iss_addr] <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              byp_hit;
            logic              zero_hit;

            assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
            // Bypass is suppressed in reset so reads show the reset contents.
            assign byp_hit  = BYPASS && reset_n && wr_en && (wr_addr == addr);
            assign zero_hit = ZERO_REG && (addr == '0);

            assign rd_data[gi*DATA_W +: DATA_W] = !rd_en[gi] ? '0 :
                                                  zero_hit   ? '0 :
                                                  byp_hit    ? wr_data :
                                                               regs_reg[addr];
            assign rd_busy[gi] = rd_en[gi] && pend_reg[addr] && !byp_hit && !zero_hit;
        end
    endgenerate

endmodule
